// File: rtl/puf_pkg.sv
// Shared types and default sizing for the PUF evaluation controller.
package puf_pkg;

  localparam int DEF_CHALLENGE_SIZE = 8;
  localparam int DEF_RESPONSE_WIDTH = 24;
  localparam int DEF_NUM_EVAL       = 5;

  // Controller states: one evaluation is RST -> WAIT -> SAMPLE, repeated NUM_EVAL times.
  typedef enum logic [2:0] {
    IDLE,
    RST,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit vote accumulator: counts ones across evaluations and decodes the
// majority value and the disagreement mask when the last evaluation lands.
module puf_vote_acc
  import puf_pkg::*;
#(
  parameter int RESPONSE_WIDTH = DEF_RESPONSE_WIDTH,
  parameter int NUM_EVAL       = DEF_NUM_EVAL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      sample,
  input  logic                      finish,
  input  logic [RESPONSE_WIDTH-1:0] response,
  output logic [RESPONSE_WIDTH-1:0] rsp_data,
  output logic [RESPONSE_WIDTH-1:0] rsp_unstable
);

  localparam int              VW   = $clog2(NUM_EVAL + 1);
  localparam logic [VW-1:0]   HALF = VW'(NUM_EVAL / 2);
  localparam logic [VW-1:0]   FULL = VW'(NUM_EVAL);

  logic [VW-1:0]             vote_q [RESPONSE_WIDTH];
  logic [VW-1:0]             vote_d [RESPONSE_WIDTH];
  logic [RESPONSE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [RESPONSE_WIDTH-1:0] rsp_unstable_q, rsp_unstable_d;

  // Next vote counts, and majority/unstable decode taken from them so the
  // final sample is included in the result latched on entry to DONE.
  always_comb begin
    rsp_data_d     = rsp_data_q;
    rsp_unstable_d = rsp_unstable_q;
    for (int i = 0; i < RESPONSE_WIDTH; i++) begin
      vote_d[i] = vote_q[i];
      if (clear) begin
        vote_d[i] = '0;
      end else if (sample && response[i]) begin
        vote_d[i] = vote_q[i] + 1'b1;
      end
    end
    if (finish) begin
      for (int i = 0; i < RESPONSE_WIDTH; i++) begin
        rsp_data_d[i]     = (vote_d[i] > HALF);
        rsp_unstable_d[i] = (vote_d[i] != '0) && (vote_d[i] != FULL);
      end
    end
  end

  // Vote counters and registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the vote array is reset explicitly; an aborted evaluation must
      // leave no stale counts even though a new request also clears them.
      for (int i = 0; i < RESPONSE_WIDTH; i++) vote_q[i] <= '0;
      rsp_data_q     <= '0;
      rsp_unstable_q <= '0;
    end else begin
      for (int i = 0; i < RESPONSE_WIDTH; i++) vote_q[i] <= vote_d[i];
      rsp_data_q     <= rsp_data_d;
      rsp_unstable_q <= rsp_unstable_d;
    end
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_unstable = rsp_unstable_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: accepts a challenge, resets and samples the PUF
// NUM_EVAL times, and returns a bitwise majority response with an unstable mask.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHALLENGE_SIZE = DEF_CHALLENGE_SIZE,
  parameter int RESPONSE_WIDTH = DEF_RESPONSE_WIDTH,
  parameter int NUM_EVAL       = DEF_NUM_EVAL,
  parameter int SETTLE         = RESPONSE_WIDTH + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CHALLENGE_SIZE-1:0] req_challenge,
  output logic [CHALLENGE_SIZE-1:0] puf_challenge,
  output logic                      puf_reset,
  input  logic [RESPONSE_WIDTH-1:0] puf_response,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RESPONSE_WIDTH-1:0] rsp_data,
  output logic [RESPONSE_WIDTH-1:0] rsp_unstable,
  output logic                      busy
);

  localparam int            TW          = $clog2(SETTLE + 1);
  localparam int            EW          = $clog2(NUM_EVAL + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [EW-1:0] EVAL_LAST   = EW'(NUM_EVAL - 1);

  state_e                    state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [EW-1:0]             eval_q, eval_d;
  logic [CHALLENGE_SIZE-1:0] challenge_q, challenge_d;
  logic                      req_ready_q, req_ready_d;
  logic                      busy_q, busy_d;
  logic                      puf_reset_q, puf_reset_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      vote_clear, vote_sample, vote_finish;

  // Next-state logic; registered outputs are derived from the next state so
  // every output comes straight from a flop.
  always_comb begin
    // NOTE: every signal gets its default first, so no branch can infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    eval_d      = eval_q;
    challenge_d = challenge_q;
    vote_clear  = 1'b0;
    vote_sample = 1'b0;
    vote_finish = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          challenge_d = req_challenge;
          eval_d      = '0;
          timer_d     = '0;
          vote_clear  = 1'b1;
          state_d     = RST;
        end
      end
      RST: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q == SETTLE_LAST) state_d = SAMPLE;
        else                        timer_d = timer_q + 1'b1;
      end
      SAMPLE: begin
        vote_sample = 1'b1;
        eval_d      = eval_q + 1'b1;
        if (eval_q == EVAL_LAST) begin
          vote_finish = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RST;
        end
      end
      DONE: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    puf_reset_d = (state_d == WAIT) || (state_d == SAMPLE);
    rsp_valid_d = (state_d == DONE);
  end

  // State, timers and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      eval_q      <= '0;
      challenge_q <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      puf_reset_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together at the edge.
      state_q     <= state_d;
      timer_q     <= timer_d;
      eval_q      <= eval_d;
      challenge_q <= challenge_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      puf_reset_q <= puf_reset_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  puf_vote_acc #(
    .RESPONSE_WIDTH(RESPONSE_WIDTH),
    .NUM_EVAL      (NUM_EVAL)
  ) u_vote_acc (
    .clk         (clk),
    .reset       (reset),
    .clear       (vote_clear),
    .sample      (vote_sample),
    .finish      (vote_finish),
    .response    (puf_response),
    .rsp_data    (rsp_data),
    .rsp_unstable(rsp_unstable)
  );

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign puf_reset     = puf_reset_q;
  assign rsp_valid     = rsp_valid_q;
  assign puf_challenge = challenge_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl with a scripted stub PUF.
module tb_puf_eval_ctrl;

  localparam int CW  = 8;
  localparam int RW  = 24;
  localparam int NE  = 5;
  localparam int ST  = RW + 2;
  localparam int LAT = NE * (ST + 2);

  typedef logic [RW-1:0] resp_arr_t [NE];
  typedef struct {
    logic [CW-1:0] chal;
    resp_arr_t     resp;
    int            hold;
    bit            noisy;
    logic [RW-1:0] exp_data;
    logic [RW-1:0] exp_unst;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] req_challenge = '0;
  logic          req_ready, rsp_valid, busy, puf_reset;
  logic [CW-1:0] puf_challenge;
  logic [RW-1:0] puf_response, rsp_data, rsp_unstable;

  int checks = 0;
  int errors = 0;

  // Stub PUF: one scripted response per evaluation; evaluation k is the
  // interval after the k-th falling puf_reset since the accept edge.
  logic [RW-1:0] stub_tbl [8];
  int            fall_cnt = 0;
  int            base_cnt = 0;
  int            stub_k;

  always #5 clk = ~clk;

  always @(negedge puf_reset) fall_cnt++;

  always_comb begin
    stub_k = fall_cnt - base_cnt;
    if (stub_k < 0) stub_k = 0;
    if (stub_k > 7) stub_k = 7;
    // Garbage while the PUF is held in reset, so a mistimed sample shows up.
    puf_response = puf_reset ? stub_tbl[stub_k] : ~stub_tbl[stub_k];
  end

  puf_eval_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_challenge(req_challenge),
    .puf_challenge(puf_challenge),
    .puf_reset    (puf_reset),
    .puf_response (puf_response),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_unstable (rsp_unstable),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: strict per-bit majority over all evaluations; a bit is
  // unstable unless every evaluation agreed.
  function automatic void model(input resp_arr_t r, output logic [RW-1:0] d,
                                output logic [RW-1:0] u);
    int ones;
    d = '0;
    u = '0;
    for (int b = 0; b < RW; b++) begin
      ones = 0;
      for (int e = 0; e < NE; e++) ones += int'(r[e][b]);
      d[b] = (2 * ones > NE);
      u[b] = (ones > 0) && (ones < NE);
    end
  endfunction

  function automatic vec_t mk(input logic [CW-1:0] c, input logic [RW-1:0] r0, r1, r2, r3, r4,
                              input int hold, input bit noisy,
                              input logic [RW-1:0] ed, input logic [RW-1:0] eu);
    vec_t v;
    v.chal     = c;
    v.resp[0]  = r0;
    v.resp[1]  = r1;
    v.resp[2]  = r2;
    v.resp[3]  = r3;
    v.resp[4]  = r4;
    v.hold     = hold;
    v.noisy    = noisy;
    v.exp_data = ed;
    v.exp_unst = eu;
    return v;
  endfunction

  task automatic load_stub(input resp_arr_t r);
    for (int e = 0; e < 8; e++) stub_tbl[e] = '0;
    for (int e = 0; e < NE; e++) stub_tbl[e] = r[e];
  endtask

  // Waits for req_ready (bounded), then presents the request for one edge.
  task automatic accept(input logic [CW-1:0] chal, input string tag, output bit ok);
    int cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    ok = (req_ready === 1'b1);
    if (!ok) return;
    req_challenge = chal;
    req_valid     = 1'b1;
    @(posedge clk);
    base_cnt = fall_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "/busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "/chal_after_accept"}, 32'(puf_challenge), 32'(chal));
  endtask

  task automatic run_request(input vec_t v, input string tag);
    int            cyc, rises;
    logic          prev_pr;
    bit            ok, chal_ok, stable_ok;
    logic [RW-1:0] d0, u0;
    load_stub(v.resp);
    accept(v.chal, tag, ok);
    if (!ok) return;
    cyc     = 0;
    rises   = 0;
    prev_pr = puf_reset;
    chal_ok = 1'b1;
    while (rsp_valid !== 1'b1 && cyc < LAT + 50) begin
      if (v.noisy) begin
        req_valid     = 1'($urandom_range(0, 1));
        req_challenge = CW'($urandom);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (puf_challenge !== v.chal) chal_ok = 1'b0;
      if (puf_reset === 1'b1 && prev_pr === 1'b0) rises++;
      prev_pr = puf_reset;
    end
    req_valid = 1'b0;
    check({tag, "/latency"}, 32'(cyc), 32'(LAT));
    check({tag, "/puf_reset_pulses"}, 32'(rises), 32'(NE));
    check({tag, "/chal_held"}, 32'(chal_ok), 32'd1);
    if (rsp_valid !== 1'b1) return;
    check({tag, "/rsp_data"}, 32'(rsp_data), 32'(v.exp_data));
    check({tag, "/rsp_unstable"}, 32'(rsp_unstable), 32'(v.exp_unst));
    check({tag, "/req_ready_in_done"}, 32'(req_ready), 32'd0);
    d0        = rsp_data;
    u0        = rsp_unstable;
    stable_ok = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_unstable !== u0 || req_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    if (v.hold > 0) check({tag, "/done_stable"}, 32'(stable_ok), 32'd1);
    rsp_ready = 1'b1;
    if (v.noisy) begin
      req_valid     = 1'b1;
      req_challenge = ~v.chal;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, "/rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    check({tag, "/idle_after_hs"}, {30'd0, req_ready, busy}, 32'b10);
    check({tag, "/chal_after_hs"}, 32'(puf_challenge), 32'(v.chal));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "/rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "/rsp_unstable"}, 32'(rsp_unstable), 32'd0);
    check({tag, "/puf_challenge"}, 32'(puf_challenge), 32'd0);
    check({tag, "/puf_reset"}, 32'(puf_reset), 32'd0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  vec_t          vecs [7];
  vec_t          rv;
  bit            ok;
  logic [RW-1:0] base_word;

  initial begin
    for (int e = 0; e < 8; e++) stub_tbl[e] = '0;
    #2 reset = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check("por/ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("por/ready_first_edge", 32'(req_ready), 32'd1);

    vecs[0] = mk(8'h3C, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5,
                 0, 1'b0, 24'hA5A5A5, 24'h000000);
    // Byte 1 also disagrees between the two patterns (FF vs 00), so it is unstable too.
    vecs[1] = mk(8'h81, 24'h00FFFF, 24'hFF00F0, 24'h00FFFF, 24'hFF00F0, 24'h00FFFF,
                 10, 1'b0, 24'h00FFFF, 24'hFFFF0F);
    vecs[2] = mk(8'h00, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
                 0, 1'b1, 24'h000000, 24'h000000);
    vecs[3] = mk(8'hFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                 2, 1'b0, 24'hFFFFFF, 24'h000000);
    vecs[4] = mk(8'h5A, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF,
                 1, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    vecs[5] = mk(8'hC3, 24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000,
                 3, 1'b1, 24'h000000, 24'hFFFFFF);
    vecs[6] = mk(8'h12, 24'h000001, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
                 0, 1'b0, 24'h000000, 24'h000001);

    for (int i = 0; i < 7; i++) run_request(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the second evaluation's settle window.
    load_stub(vecs[0].resp);
    accept(8'h77, "abort", ok);
    if (ok) begin
      repeat ((ST + 2) + 1 + ST / 2) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("abort/in_wait", {30'd0, puf_reset, busy}, 32'b11);
      reset = 1'b0;
      #1 check_reset_values("abort");
      repeat (3) @(negedge clk);
      check("abort/no_partial", 32'(rsp_valid), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1 check("abort/ready_first_edge", 32'(req_ready), 32'd1);
    end
    run_request(vecs[1], "after_abort");

    for (int n = 0; n < 4; n++) begin
      base_word = RW'($urandom);
      for (int e = 0; e < NE; e++)
        rv.resp[e] = base_word ^ (RW'($urandom) & RW'($urandom) & RW'($urandom));
      rv.chal  = CW'($urandom);
      rv.hold  = int'($urandom_range(0, 3));
      rv.noisy = 1'($urandom_range(0, 1));
      model(rv.resp, rv.exp_data, rv.exp_unst);
      run_request(rv, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
